// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: the execute-stage bundle, the access FSM states and lane helpers.
package mem_access_unit_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_ADDR_W = 16;

    typedef struct packed {
        logic [1:0]            mem_read;
        logic [1:0]            mem_write;
        logic [ALU_ADDR_W-1:0] mem_addr;
        logic [ALU_DATA_W-1:0] data_out;
        logic [3:0]            rd;
        logic                  reg_write;
    } alu_signals;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} mem_state_e;

    // Bit position of the low end of byte lane 'lane' within a data_w-wide word.
    function automatic int lane_lsb(input int lane, input int data_w, input logic big);
        return big ? (data_w - 8 - 8 * lane) : (8 * lane);
    endfunction

    // Byte-enable for one lane: one-hot for bytes, full for unsplit words, upper/lower part per beat when split.
    function automatic logic lane_en(input int lane, input int off, input logic word,
                                     input logic split, input logic beat);
        if (!word)  return lane == off;
        if (!split) return 1'b1;
        return beat ? (lane < off) : (lane >= off);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte select/extend, store replicate/rotate, byte enables, split-read merge.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter bit BIG_ENDIAN = 1'b1,
    localparam int BYTES     = DATA_W / 8,
    localparam int LG        = $clog2(BYTES)
) (
    input  logic              is_word,
    input  logic              split,
    input  logic              beat,
    input  logic [LG-1:0]     offset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] stage,
    output logic [BYTES-1:0]  be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] byte_rd;
    int                off;
    int                src;

    always_comb begin
        be      = '0;
        wdata   = wr_data;
        merged  = '0;
        byte_rd = '0;
        off     = int'(offset);
        src     = 0;
        for (int l = 0; l < BYTES; l++) begin
            be[l] = lane_en(l, off, is_word, split, beat);
            if (!is_word)
                wdata[lane_lsb(l, DATA_W, BIG_ENDIAN) +: 8] = wr_data[7:0];
            else if (split)
                wdata[lane_lsb(l, DATA_W, BIG_ENDIAN) +: 8] =
                    wr_data[lane_lsb((l + BYTES - off) % BYTES, DATA_W, BIG_ENDIAN) +: 8];
            // Word byte l sits at lane l+off: in the staged first beat, or wrapped into the second.
            src = l + off;
            if (src < BYTES)
                merged[lane_lsb(l, DATA_W, BIG_ENDIAN) +: 8] = stage[lane_lsb(src, DATA_W, BIG_ENDIAN) +: 8];
            else
                merged[lane_lsb(l, DATA_W, BIG_ENDIAN) +: 8] = rd_data[lane_lsb(src - BYTES, DATA_W, BIG_ENDIAN) +: 8];
        end
        byte_rd[7:0] = rd_data[lane_lsb(off, DATA_W, BIG_ENDIAN) +: 8];
        rdata = !is_word ? byte_rd : (split ? merged : rd_data);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: non-memory ops pass in 1 cycle; loads/stores take 1 + one per beat + bus waits, stall_o held meanwhile.
// Optional MEM_UNALIGNED_EN splits misaligned words into two beats; otherwise they run aligned and flag misalign_o.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W     = ALU_DATA_W,
    parameter int ADDR_W     = ALU_ADDR_W,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  alu_signals           ctrl_i,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic [DATA_W/8-1:0]  mem_be_o,
    output logic [DATA_W-1:0]    mem_data_o,
    input  logic [DATA_W-1:0]    mem_data_i,
    input  logic                 mem_ready_i,
    output logic                 stall_o,
    output alu_signals           ctrl_o,
    output logic                 valid_o,
    output logic                 misalign_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int LG    = $clog2(BYTES);

    mem_state_e        state, state_nxt;
    alu_signals        req, result;
    logic              ctrl_mem, req_read, req_word, req_misal, split, complete;
    logic [LG-1:0]     offset;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] stage, lane_wdata, lane_rdata;
    logic [BYTES-1:0]  lane_be;

    assign ctrl_mem  = ctrl_i.mem_read[0] | ctrl_i.mem_write[0];
    assign req_read  = req.mem_read[0];
    assign req_word  = req_read ? req.mem_read[1] : req.mem_write[1];
    assign offset    = req.mem_addr[LG-1:0];
    assign base      = {req.mem_addr[ADDR_W-1:LG], {LG{1'b0}}};
    assign req_misal = req_word && (offset != '0);
    assign complete  = mem_ready_i && ((state == BEAT0 && !split) || state == BEAT1);

`ifdef MEM_UNALIGNED_EN
    assign split = req_misal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stage <= '0;
        else if (state == BEAT0 && mem_ready_i && split)
            stage <= mem_data_i;
    end
`else
    assign split = 1'b0;
    assign stage = '0;
`endif

    mem_lane_align #(.DATA_W(DATA_W), .BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .is_word (req_word),
        .split   (split),
        .beat    (state == BEAT1),
        .offset  (offset),
        .wr_data (req.data_out),
        .rd_data (mem_data_i),
        .stage   (stage),
        .be      (lane_be),
        .wdata   (lane_wdata),
        .rdata   (lane_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (en && ctrl_mem) state_nxt = BEAT0;
            BEAT0: if (mem_ready_i)    state_nxt = split ? BEAT1 : IDLE;
`ifdef MEM_UNALIGNED_EN
            BEAT1: if (mem_ready_i)    state_nxt = IDLE;
`endif
            default:                   state_nxt = IDLE;
        endcase
    end

    // Bus side decodes only registered state and request, so a reset drops the request at once.
    always_comb begin
        mem_re_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_be_o   = '0;
        mem_data_o = '0;
        stall_o    = (state != IDLE);
        if (state != IDLE) begin
            mem_re_o   = req_read;
            mem_we_o   = !req_read && req.mem_write[0];
            mem_addr_o = (state == BEAT1) ? base + ADDR_W'(BYTES) : base;
            mem_be_o   = lane_be;
            mem_data_o = req_read ? '0 : lane_wdata;
        end
        result = req;
        if (req_read)
            result.data_out = lane_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req        <= '0;
            ctrl_o     <= '0;
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            if (state == IDLE && en) begin
                if (ctrl_mem) begin
                    req <= ctrl_i;
                end else begin
                    ctrl_o  <= ctrl_i;
                    valid_o <= 1'b1;
                end
            end else if (complete) begin
                ctrl_o     <= result;
                valid_o    <= 1'b1;
                misalign_o <= req_misal & ~split;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit at DATA_W=16, big-endian; covers both MEM_UNALIGNED_EN builds.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, mem_re_o, mem_we_o, mem_ready_i, stall_o, valid_o, misalign_o;
    alu_signals  ctrl_i, ctrl_o;
    logic [15:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [1:0]  mem_be_o;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .en(en), .ctrl_i(ctrl_i),
        .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ready_i(mem_ready_i), .stall_o(stall_o), .ctrl_o(ctrl_o),
        .valid_o(valid_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr; logic re; logic we; logic [1:0] be;
        logic [15:0] wd; logic [15:0] dm; logic [15:0] rd; int waits;
    } beat_t;
    typedef struct { alu_signals c; logic mis; int cyc; } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    total = 0, bad = 0, cyc = 0, wleft = 0;
    bit    in_beat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic alu_signals mk(input logic [1:0] r, input logic [1:0] w,
                                      input logic [15:0] a, input logic [15:0] d);
        alu_signals s;
        s.mem_read = r; s.mem_write = w; s.mem_addr = a; s.data_out = d;
        s.rd = 4'h5; s.reg_write = 1'b1;
        return s;
    endfunction

    function automatic void push_beat(input logic [15:0] addr, input logic re, input logic we,
                                      input logic [1:0] be, input logic [15:0] wd, input logic [15:0] dm,
                                      input logic [15:0] rd, input int waits);
        beat_q.push_back('{addr:addr, re:re, we:we, be:be, wd:wd, dm:dm, rd:rd, waits:waits});
    endfunction

    // Bus responder and beat checker: compares every cycle a beat is presented, completes after its waits.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            in_beat = 1'b0; wleft = 0; mem_ready_i = 1'b0;
        end else if (mem_re_o || mem_we_o) begin
            if (beat_q.size() == 0) begin
                total++; bad++; mem_ready_i = 1'b0;
                $display("FAIL unexpected_beat: addr %h re %b we %b, expected no bus request", mem_addr_o, mem_re_o, mem_we_o);
            end else begin
                b = beat_q[0];
                if (!in_beat) begin in_beat = 1'b1; wleft = b.waits; end
                chk("beat_addr", mem_addr_o, b.addr);
                chk("beat_re", mem_re_o, b.re);
                chk("beat_we", mem_we_o, b.we);
                chk("beat_be", mem_be_o, b.be);
                chk("beat_wdata", mem_data_o & b.dm, b.wd);
                if (wleft > 0) begin
                    wleft--; mem_ready_i = 1'b0;
                end else begin
                    mem_ready_i = 1'b1; mem_data_i = b.rd;
                    void'(beat_q.pop_front()); in_beat = 1'b0;
                end
            end
        end else begin
            mem_ready_i = 1'b0;
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        res_t r;
        if (!rst && valid_o) begin
            if (res_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: ctrl_o %h, expected no result", ctrl_o);
            end else begin
                r = res_q.pop_front();
                chk("ctrl_o", ctrl_o, r.c);
                chk("misalign_o", misalign_o, r.mis);
                chk("valid_cycle", cyc, r.cyc);
            end
        end
    end

    task automatic send(input alu_signals c, input int lat, input alu_signals e, input logic mis);
        @(negedge clk);
        ctrl_i = c; en = 1'b1;
        res_q.push_back('{c:e, mis:mis, cyc:cyc + lat});
        @(negedge clk);
        en = 1'b0; ctrl_i = '0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((res_q.size() != 0 || beat_q.size() != 0) && n < 100) begin
            @(negedge clk); n++;
        end
        total++;
        if (res_q.size() != 0 || beat_q.size() != 0) begin
            bad++;
            $display("FAIL %s: timeout with %0d results and %0d beats outstanding, expected 0", name, res_q.size(), beat_q.size());
            res_q.delete(); beat_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic reset_mid_beat(input alu_signals c, input int settle);
        @(negedge clk);
        ctrl_i = c; en = 1'b1;
        @(negedge clk);
        en = 1'b0; ctrl_i = '0;
        repeat (settle) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_re_drop", mem_re_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_addr", mem_addr_o, 16'h0000);
        beat_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", stall_o, 1'b0);
    endtask

    initial begin
        alu_signals c, e;
        int nst;
        rst = 1'b1; en = 1'b0; ctrl_i = '0; mem_ready_i = 1'b0; mem_data_i = '0;
        #12;
        chk("rst_re", mem_re_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_be", mem_be_o, 2'b00);
        chk("rst_addr0", mem_addr_o, 16'h0000);
        chk("rst_wdata", mem_data_o, 16'h0000);
        chk("rst_stall0", stall_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_misalign", misalign_o, 1'b0);
        chk("rst_ctrl_o", ctrl_o, 41'h0);
        @(negedge clk);
        rst = 1'b0;

        c = mk(2'b01, 2'b00, 16'h1001, 16'h5555);
        push_beat(16'h1000, 1'b1, 1'b0, 2'b10, 16'h0, 16'h0, 16'hABCD, 0);
        e = c; e.data_out = 16'h00CD;
        send(c, 2, e, 1'b0);
        drain("byte_read");

        c = mk(2'b00, 2'b01, 16'h2000, 16'h0012);
        push_beat(16'h2000, 1'b0, 1'b1, 2'b01, 16'h1212, 16'hFFFF, 16'h0, 0);
        send(c, 2, c, 1'b0);
        drain("byte_write");

        // Word read with three wait cycles while en toggles and a decoy store sits on ctrl_i.
        c = mk(2'b11, 2'b00, 16'h4000, 16'h0000);
        push_beat(16'h4000, 1'b1, 1'b0, 2'b11, 16'h0, 16'h0, 16'h1234, 3);
        e = c; e.data_out = 16'h1234;
        @(negedge clk);
        ctrl_i = c; en = 1'b1;
        res_q.push_back('{c:e, mis:1'b0, cyc:cyc + 5});
        nst = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (stall_o) nst++;
            en = (i % 2 == 0) && (i < 5);
            ctrl_i = mk(2'b00, 2'b01, 16'h7777, 16'h00EE);
        end
        ctrl_i = '0; en = 1'b0;
        chk("stall_cycles", nst, 4);
        drain("word_read_wait");

        c = mk(2'b00, 2'b00, 16'h0044, 16'hBEEF);
        send(c, 1, c, 1'b0);
        drain("non_mem");

        @(negedge clk);
        ctrl_i = mk(2'b01, 2'b00, 16'h0100, 16'h0000); en = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_low_no_accept", stall_o, 1'b0);
        ctrl_i = '0;

        c = mk(2'b00, 2'b11, 16'h5002, 16'hCAFE);
        push_beat(16'h5002, 1'b0, 1'b1, 2'b11, 16'hCAFE, 16'hFFFF, 16'h0, 0);
        send(c, 2, c, 1'b0);
        drain("word_write");

`ifdef MEM_UNALIGNED_EN
        c = mk(2'b11, 2'b00, 16'h3001, 16'h0000);
        push_beat(16'h3000, 1'b1, 1'b0, 2'b10, 16'h0, 16'h0, 16'h11AA, 0);
        push_beat(16'h3002, 1'b1, 1'b0, 2'b01, 16'h0, 16'h0, 16'hBB22, 0);
        e = c; e.data_out = 16'hAABB;
        send(c, 3, e, 1'b0);
        drain("split_read");

        c = mk(2'b00, 2'b11, 16'h3001, 16'hAABB);
        push_beat(16'h3000, 1'b0, 1'b1, 2'b10, 16'h00AA, 16'h00FF, 16'h0, 0);
        push_beat(16'h3002, 1'b0, 1'b1, 2'b01, 16'hBB00, 16'hFF00, 16'h0, 0);
        send(c, 3, c, 1'b0);
        drain("split_write");

        c = mk(2'b00, 2'b11, 16'hFFFF, 16'h1357);
        push_beat(16'hFFFE, 1'b0, 1'b1, 2'b10, 16'h0013, 16'h00FF, 16'h0, 0);
        push_beat(16'h0000, 1'b0, 1'b1, 2'b01, 16'h5700, 16'hFF00, 16'h0, 1);
        send(c, 4, c, 1'b0);
        drain("split_wrap");

        push_beat(16'h3000, 1'b1, 1'b0, 2'b10, 16'h0, 16'h0, 16'h11AA, 0);
        push_beat(16'h3002, 1'b1, 1'b0, 2'b01, 16'h0, 16'h0, 16'h0000, 50);
        reset_mid_beat(mk(2'b11, 2'b00, 16'h3001, 16'h0000), 2);
`else
        c = mk(2'b11, 2'b00, 16'h3001, 16'h0000);
        push_beat(16'h3000, 1'b1, 1'b0, 2'b11, 16'h0, 16'h0, 16'h11AA, 0);
        e = c; e.data_out = 16'h11AA;
        send(c, 2, e, 1'b1);
        drain("misaligned_read");

        c = mk(2'b00, 2'b11, 16'h3001, 16'hAABB);
        push_beat(16'h3000, 1'b0, 1'b1, 2'b11, 16'hAABB, 16'hFFFF, 16'h0, 0);
        send(c, 2, c, 1'b1);
        drain("misaligned_write");

        c = mk(2'b00, 2'b11, 16'hFFFF, 16'h1357);
        push_beat(16'hFFFE, 1'b0, 1'b1, 2'b11, 16'h1357, 16'hFFFF, 16'h0, 1);
        send(c, 3, c, 1'b1);
        drain("misaligned_top");

        push_beat(16'h6000, 1'b1, 1'b0, 2'b11, 16'h0, 16'h0, 16'h0000, 50);
        reset_mid_beat(mk(2'b11, 2'b00, 16'h6000, 16'h0000), 1);
`endif

        c = mk(2'b01, 2'b00, 16'h7000, 16'h0000);
        push_beat(16'h7000, 1'b1, 1'b0, 2'b01, 16'h0, 16'h0, 16'h9A00, 0);
        e = c; e.data_out = 16'h009A;
        send(c, 2, e, 1'b0);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
